// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational one-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: LSB-first through one full-adder cell and a carry flop,
// with valid/ready handshakes on both sides and a held result.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic               fa_s;
    logic               fa_co;
    logic [WIDTH:0]     res_next_s;
    logic               last_step_s;

    fa_cell u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New result bit enters at the MSB; the top WIDTH bits are the shifted register.
    assign res_next_s  = {fa_s, res_sh_q};
    assign last_step_s = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath update for the IDLE/RUN/HOLD sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1, so the inverted operand and forced carry suffice.
                    a_sh_d     = a;
                    b_sh_d     = sub ? ~b : b;
                    carry_d    = sub ? 1'b1 : cin;
                    cnt_d      = {CNT_W{1'b0}};
                    res_sh_d   = {WIDTH{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                carry_d  = fa_co;
                res_sh_d = res_next_s[WIDTH:1];
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1'b1);
                if (last_step_s) begin
                    // carry_q here is the carry into the MSB.
                    sum_d       = res_next_s[WIDTH:1];
                    cout_d      = fa_co;
                    ovf_d       = carry_q ^ fa_co;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    state_d     = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            res_sh_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed and random operations against
// an arithmetic reference model, plus a WIDTH=1 instance.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, sum;
    logic       cin, sub, cout, ovf;

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0] a1, b1, sum1;
    logic       cin1, sub1, cout1, ovf1;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mcin, input logic msub);
        int ua, ub, sa, sb, ur, sr;
        logic [7:0] rs;
        logic rc, ro;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            ur = ua - ub;
            sr = sa - sb;
            rc = (ua >= ub);
        end else begin
            ur = ua + ub + int'(mcin);
            sr = sa + sb + int'(mcin);
            rc = (ur > 255);
        end
        rs = ur[7:0];
        ro = (sr > 127) || (sr < -128);
        return {ro, rc, rs};
    endfunction

    // Issue one operation from IDLE, check latency, result and handshake.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                          input logic tsub, input int hold, input string tag);
        logic [9:0] exp;
        int lat;
        exp = model(ta, tb_, tcin, tsub);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 24) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(exp[8]));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp[9]));
        repeat (hold) @(negedge clk);
        chk({tag, "_held_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_held_sum"}, 32'(sum), 32'(exp[7:0]));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_sum_kept"}, 32'(sum), 32'(exp[7:0]));
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0; cin = 1'b0; sub = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, with explicit expected values alongside the model.
        run_op(8'd5, 8'd3, 1'b0, 1'b0, 3, "add_5_3");
        chk("add_5_3_const", 32'(sum), 32'd8);
        run_op(8'd255, 8'd1, 1'b0, 1'b0, 0, "add_wrap");
        chk("add_wrap_cout", 32'(cout), 32'd1);
        run_op(8'd127, 8'd1, 1'b0, 1'b0, 0, "add_ovf");
        chk("add_ovf_const", 32'({ovf, sum}), 32'({1'b1, 8'd128}));
        run_op(8'd5, 8'd7, 1'b1, 1'b1, 1, "sub_borrow");
        chk("sub_borrow_const", 32'({ovf, cout, sum}), 32'({1'b0, 1'b0, 8'd254}));
        run_op(8'd128, 8'd1, 1'b0, 1'b1, 0, "sub_ovf");
        chk("sub_ovf_const", 32'({ovf, cout, sum}), 32'({1'b1, 1'b1, 8'd127}));

        // Reset in the middle of RUN.
        a = 8'd200; b = 8'd100; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrun_rst_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_ready", 32'(in_ready), 32'd1);
        chk("midrun_rst_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd5, 8'd3, 1'b0, 1'b0, 0, "after_rst");

        // Long HOLD with new operands presented: they must be ignored.
        a = 8'd10; b = 8'd20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'd99; b = 8'd1; sub = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'd30);
            chk("hold_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_release_valid", 32'(out_valid), 32'd0);
        chk("hold_release_ready", 32'(in_ready), 32'd1);
        chk("hold_release_sum", 32'(sum), 32'd30);

        // Randomized operations against the model.
        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "rand");
        end

        // WIDTH=1 instance: 1+1+1.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; sub1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("w1_not_yet", 32'(out_valid1), 32'd0);
        @(negedge clk);
        chk("w1_valid", 32'(out_valid1), 32'd1);
        chk("w1_sum", 32'(sum1), 32'd1);
        chk("w1_cout", 32'(cout1), 32'd1);
        chk("w1_ovf", 32'(ovf1), 32'd0);
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("w1_consumed", 32'(out_valid1), 32'd0);
        chk("w1_ready", 32'(in_ready1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
